// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared CPU definitions used by the instruction/data memory bus arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ADDR, RESP)
//   - owner_e     : identity of the master owning the bus (INST=0, DATA=1)
//   - pick_winner : fixed-priority selection between the two masters
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  ZERO_STRB = 4'b0000;

  // Fixed priority: the data port wins a tie when data_first is set,
  // otherwise the instruction port wins.
  function automatic owner_e pick_winner(input logic inst_req,
                                         input logic data_req,
                                         input logic data_first);
    owner_e win;
    if (data_req && (data_first || !inst_req)) begin
      win = OWNER_DATA;
    end else begin
      win = OWNER_INST;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates the core's instruction and data ports onto a single memory bus,
// one transaction outstanding at a time.
//
// Ports
//   clk, resetn                       clock, async active-low reset
//   inst_req/inst_addr                fetch request from the instruction port
//   inst_addr_ok/inst_data_ok         accept / response pulses to that port
//   inst_rdata                        fetched word (valid with inst_data_ok)
//   data_req/data_wstrb/data_addr/    load/store request from the data port
//   data_wdata
//   data_addr_ok/data_data_ok         accept / response pulses to that port
//   data_rdata                        loaded word (valid with data_data_ok)
//   bus_req/bus_wstrb/bus_addr/       request towards memory, fields latched
//   bus_wdata                         at grant time
//   bus_addr_ok/bus_data_ok/bus_rdata memory handshake and read data
//   err                               sticky flag for unexpected bus_data_ok
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  arb_state_e state_r;
  arb_state_e state_s;
  owner_e     owner_r;
  owner_e     winner_s;
  logic       grant_s;
  logic       resp_s;
  logic       spurious_s;

  // Next-state, grant, response and protocol-error decode.
  always_comb begin
    state_s    = state_r;
    winner_s   = pick_winner(inst_req, data_req, DATA_FIRST);
    grant_s    = 1'b0;
    resp_s     = 1'b0;
    spurious_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The accept pulse is combinational, so it is masked while reset is
        // asserted to keep every addr_ok low during reset.
        if (resetn && (inst_req || data_req)) begin
          grant_s = 1'b1;
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
        if (bus_data_ok) begin
          spurious_s = 1'b1;
        end else begin
          spurious_s = 1'b0;
        end
      end
      ST_ADDR: begin
        if (bus_addr_ok) begin
          // Zero-latency memory completes the whole transaction here.
          if (bus_data_ok) begin
            resp_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          if (bus_data_ok) begin
            spurious_s = 1'b1;
          end else begin
            spurious_s = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (bus_data_ok) begin
          resp_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Owner bit and request fields captured at grant; they stay frozen for the
  // whole transaction regardless of what the masters do afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r   <= OWNER_INST;
      bus_addr  <= ZERO_WORD;
      bus_wstrb <= ZERO_STRB;
      bus_wdata <= ZERO_WORD;
    end else if (grant_s) begin
      owner_r <= winner_s;
      if (winner_s == OWNER_DATA) begin
        bus_addr  <= data_addr;
        bus_wstrb <= data_wstrb;
        bus_wdata <= data_wdata;
      end else begin
        bus_addr  <= inst_addr;
        bus_wstrb <= ZERO_STRB;
        bus_wdata <= ZERO_WORD;
      end
    end else begin
      owner_r   <= owner_r;
      bus_addr  <= bus_addr;
      bus_wstrb <= bus_wstrb;
      bus_wdata <= bus_wdata;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else begin
      err <= err | spurious_s;
    end
  end

  assign bus_req      = (state_r == ST_ADDR);
  assign inst_addr_ok = grant_s && (winner_s == OWNER_INST);
  assign data_addr_ok = grant_s && (winner_s == OWNER_DATA);
  assign inst_data_ok = resp_s && (owner_r == OWNER_INST);
  assign data_data_ok = resp_s && (owner_r == OWNER_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule
